occ_width_table: RTL and testbench



---
 rtl/occ_pkg.sv | 22 ++
 rtl/occ_sat_addsub.sv | 51 +++++
 rtl/occ_width_table.sv | 157 +++++++++++++++
 tb/tb_occ_width_table.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/occ_pkg.sv
// Shared definitions for the per-ID occupied-width table: update op
// encodings, FSM state type and default parameter values.
package occ_pkg;

    // Default geometry of the table.
    localparam int OCC_NUM_ID_DEF   = 16;
    localparam int OCC_ACC_W_DEF    = 7;
    localparam int OCC_UPD_W_DEF    = 5;
    localparam int OCC_NUM_RD_DEF   = 3;
    localparam int OCC_BLOCK_ID_DEF = 13;

    // Update opcode carried on upd_op.
    localparam logic OCC_OP_ADD = 1'b0;
    localparam logic OCC_OP_REL = 1'b1;

    // Controller state: normal operation or clear sweep.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } occ_state_t;

endpackage

// File: rtl/occ_sat_addsub.sv
// Combinational saturating add/release of one table entry. The operands are
// widened by one bit so that overflow past the full value (and underflow
// below zero) is detected before truncation. Shared by the table write path
// and the same-cycle read bypass.
module occ_sat_addsub
    import occ_pkg::*;
#(
    parameter int ACC_W = OCC_ACC_W_DEF,
    parameter int UPD_W = OCC_UPD_W_DEF
) (
    input  logic             op,
    input  logic [ACC_W-1:0] cur,
    input  logic [UPD_W-1:0] amt,
    output logic [ACC_W-1:0] res,
    output logic             sat
);

    localparam logic [ACC_W:0] WMAX_EXT = {1'b0, {ACC_W{1'b1}}};

    logic [ACC_W:0] cur_ext;
    logic [ACC_W:0] amt_ext;
    logic [ACC_W:0] sum_ext;
    logic [ACC_W:0] diff_ext;

    assign cur_ext  = {1'b0, cur};
    assign amt_ext  = (ACC_W+1)'(amt);
    assign sum_ext  = cur_ext + amt_ext;
    assign diff_ext = cur_ext - amt_ext;

    // Clamp to [0, WMAX] and flag whenever the clamp engaged.
    always_comb begin
        res = cur;
        sat = 1'b0;
        if (op == OCC_OP_ADD) begin
            if (sum_ext > WMAX_EXT) begin
                res = WMAX_EXT[ACC_W-1:0];
                sat = 1'b1;
            end else begin
                res = sum_ext[ACC_W-1:0];
            end
        end else begin
            if (amt_ext > cur_ext) begin
                res = '0;
                sat = 1'b1;
            end else begin
                res = diff_ext[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/occ_width_table.sv
// Per-ID occupied-width table. One handshaked add/release update port, NUM_RD
// registered read ports sharing one strobe, and a one-entry-per-cycle clear
// sweep. Entry BLOCK_ID is pinned at the full value (BLOCK_ID = NUM_ID
// disables the pin).
// Optional feature macro: OCC_BYPASS_EN -- a read in the same cycle as an
// accepted update to the same ID returns the post-update value.
//
// Update handshake: an update transfers on a rising edge where
// upd_valid && upd_ready. upd_ready depends only on the controller state
// (high in IDLE, low during the clear sweep), never on upd_valid, so the
// requester may hold upd_valid and its payload until the transfer edge.
module occ_width_table
    import occ_pkg::*;
#(
    parameter int NUM_ID   = OCC_NUM_ID_DEF,
    parameter int ID_W     = $clog2(NUM_ID),
    parameter int ACC_W    = OCC_ACC_W_DEF,
    parameter int UPD_W    = OCC_UPD_W_DEF,
    parameter int NUM_RD   = OCC_NUM_RD_DEF,
    parameter int BLOCK_ID = OCC_BLOCK_ID_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic                    upd_op,
    input  logic [ID_W-1:0]         upd_id,
    input  logic [UPD_W-1:0]        upd_amt,
    input  logic                    rd_en,
    input  logic [NUM_RD*ID_W-1:0]  rd_id,
    output logic [NUM_RD*ACC_W-1:0] rd_width,
    output logic                    rd_valid,
    input  logic                    clr_req,
    output logic                    busy,
    output logic                    sat_err,
    output logic [0:0]              state_dbg
);

    localparam logic [ACC_W-1:0] WMAX = '1;

    occ_state_t        state;
    logic [ID_W-1:0]   clr_idx;
    logic [ACC_W-1:0]  table_q [NUM_ID];

    logic              upd_fire;
    logic              upd_hit;
    logic [ACC_W-1:0]  upd_cur;
    logic [ACC_W-1:0]  upd_res;
    logic              upd_sat;
    logic              rd_fire;
    logic [NUM_RD*ACC_W-1:0] rd_next;

    assign upd_ready = (state == IDLE);
    assign busy      = (state == CLEAR);
    assign state_dbg = state;
    assign upd_fire  = upd_valid && upd_ready;
    assign rd_fire   = rd_en && (state == IDLE);

    // An accepted update only touches the table for a real, unpinned entry
    // with a non-zero amount; everything else is accepted and dropped.
    assign upd_hit = upd_fire && (int'(upd_id) < NUM_ID)
                     && (int'(upd_id) != BLOCK_ID) && (upd_amt != '0);

    // Current value of the entry being updated (0 for out-of-range IDs).
    always_comb begin
        upd_cur = '0;
        if (int'(upd_id) < NUM_ID) begin
            upd_cur = table_q[upd_id];
        end
    end

    occ_sat_addsub #(
        .ACC_W (ACC_W),
        .UPD_W (UPD_W)
    ) u_sat_addsub (
        .op  (upd_op),
        .cur (upd_cur),
        .amt (upd_amt),
        .res (upd_res),
        .sat (upd_sat)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ID_W-1:0] sel_id;
        assign sel_id = rd_id[k*ID_W +: ID_W];

        // Per-port read mux, optionally forwarding the in-flight update.
        always_comb begin
            rd_next[k*ACC_W +: ACC_W] = '0;
            if (int'(sel_id) < NUM_ID) begin
                rd_next[k*ACC_W +: ACC_W] = table_q[sel_id];
            end
`ifdef OCC_BYPASS_EN
            if (upd_hit && (sel_id == upd_id)) begin
                rd_next[k*ACC_W +: ACC_W] = upd_res;
            end
`else
`endif
        end
    end

    // Controller: IDLE <-> CLEAR, sweep index advances one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else if (state == IDLE) begin
            if (clr_req) begin
                state   <= CLEAR;
                clr_idx <= '0;
            end
        end else begin
            if (clr_idx == ID_W'(NUM_ID - 1)) begin
                state   <= IDLE;
                clr_idx <= '0;
            end else begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // Table storage: reset image, sweep writes, then accepted updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ID; i++) begin
                table_q[i] <= (i == BLOCK_ID) ? WMAX : '0;
            end
        end else if (state == CLEAR) begin
            table_q[clr_idx] <= (int'(clr_idx) == BLOCK_ID) ? WMAX : '0;
        end else if (upd_hit) begin
            table_q[upd_id] <= upd_res;
        end
    end

    // Registered read ports; data holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_width <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_width <= rd_next;
            end
        end
    end

    // Saturation pulse one cycle after a clamped update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_err <= 1'b0;
        end else begin
            sat_err <= upd_hit && upd_sat;
        end
    end

endmodule

// File: tb/tb_occ_width_table.sv
// Bench for occ_width_table: reset checks, a vector table of updates with
// read-back, hand sequences for clear sweep, bypass and reset-mid-sweep,
// randomized traffic against a reference model, and an out-of-range ID check
// on a 14-entry instance.
module tb_occ_width_table;
    import occ_pkg::*;

    localparam int NUM_ID   = 16;
    localparam int ID_W     = 4;
    localparam int ACC_W    = 7;
    localparam int UPD_W    = 5;
    localparam int NUM_RD   = 3;
    localparam int BLOCK_ID = 13;
    localparam int WMAX     = 127;
`ifdef OCC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (default geometry) ----------------
    logic                    upd_valid, upd_ready, upd_op;
    logic [ID_W-1:0]         upd_id;
    logic [UPD_W-1:0]        upd_amt;
    logic                    rd_en, rd_valid, clr_req, busy, sat_err;
    logic [NUM_RD*ID_W-1:0]  rd_id;
    logic [NUM_RD*ACC_W-1:0] rd_width;
    logic [0:0]              state_dbg;

    occ_width_table u_dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
        .upd_id(upd_id), .upd_amt(upd_amt),
        .rd_en(rd_en), .rd_id(rd_id), .rd_width(rd_width), .rd_valid(rd_valid),
        .clr_req(clr_req), .busy(busy), .sat_err(sat_err), .state_dbg(state_dbg)
    );

    // ---------------- DUT with 14 entries ----------------
    logic                    upd_valid_b, upd_ready_b, upd_op_b;
    logic [ID_W-1:0]         upd_id_b;
    logic [UPD_W-1:0]        upd_amt_b;
    logic                    rd_en_b, rd_valid_b, clr_req_b, busy_b, sat_err_b;
    logic [NUM_RD*ID_W-1:0]  rd_id_b;
    logic [NUM_RD*ACC_W-1:0] rd_width_b;
    logic [0:0]              state_dbg_b;

    occ_width_table #(.NUM_ID(14)) u_dut14 (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid_b), .upd_ready(upd_ready_b), .upd_op(upd_op_b),
        .upd_id(upd_id_b), .upd_amt(upd_amt_b),
        .rd_en(rd_en_b), .rd_id(rd_id_b), .rd_width(rd_width_b), .rd_valid(rd_valid_b),
        .clr_req(clr_req_b), .busy(busy_b), .sat_err(sat_err_b), .state_dbg(state_dbg_b)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_pass  = 0;
    int n_total = 0;
    int model [NUM_ID];
    logic [ACC_W-1:0] exp_q [$];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int port_w(input int k);
        return int'(rd_width[k*ACC_W +: ACC_W]);
    endfunction

    function automatic int port_wb(input int k);
        return int'(rd_width_b[k*ACC_W +: ACC_W]);
    endfunction

    // Entry after an update, from the clamping rule min/max(entry +/- amt).
    function automatic int ref_next(input int cur, input bit op, input int amt);
        if (op == 1'b0) return (cur + amt > WMAX) ? WMAX : cur + amt;
        return (amt > cur) ? 0 : cur - amt;
    endfunction

    function automatic bit ref_sat(input int cur, input bit op, input int amt);
        if (op == 1'b0) return (cur + amt > WMAX);
        return (amt > cur);
    endfunction

    function automatic bit ref_writable(input int id);
        return (id < NUM_ID) && (id != BLOCK_ID);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ID; i++) model[i] = (i == BLOCK_ID) ? WMAX : 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        upd_valid = 1'b0; upd_op = 1'b0; upd_id = '0; upd_amt = '0;
        rd_en = 1'b0; rd_id = '0; clr_req = 1'b0;
        upd_valid_b = 1'b0; upd_op_b = 1'b0; upd_id_b = '0; upd_amt_b = '0;
        rd_en_b = 1'b0; rd_id_b = '0; clr_req_b = 1'b0;
    endtask

    task automatic do_update(input bit op, input int id, input int amt);
        upd_valid = 1'b1; upd_op = op; upd_id = ID_W'(id); upd_amt = UPD_W'(amt);
        step();
        upd_valid = 1'b0;
        if (ref_writable(id)) model[id] = ref_next(model[id], op, amt);
    endtask

    task automatic read3(input int a, input int b, input int c);
        rd_en = 1'b1;
        rd_id = {ID_W'(c), ID_W'(b), ID_W'(a)};
        step();
        rd_en = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit op;
        int id;
        int amt;
        int exp_val;
        bit exp_sat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int exp_v;
        int pid;
        bit v, op, re, es, prev_re;
        int id, amt;
        int rids [NUM_RD];

        // ID 2 climbs in steps of 16 and clamps on the 8th add.
        for (int i = 0; i < 7; i++) vecs[i] = '{1'b0, 2, 16, 16 * (i + 1), 1'b0};
        vecs[7]  = '{1'b0, 2, 16, 127, 1'b1};
        vecs[8]  = '{1'b0, 2, 5, 127, 1'b1};
        vecs[9]  = '{1'b0, 2, 0, 127, 1'b0};
        vecs[10] = '{1'b0, 4, 10, 10, 1'b0};
        vecs[11] = '{1'b1, 4, 12, 0, 1'b1};
        vecs[12] = '{1'b0, 13, 9, 127, 1'b0};
        vecs[13] = '{1'b0, 15, 9, 9, 1'b0};
        vecs[14] = '{1'b1, 15, 9, 0, 1'b0};
        vecs[15] = '{1'b0, 7, 31, 31, 1'b0};
        vecs[16] = '{1'b1, 7, 0, 31, 1'b0};

        // ---- reset ----
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        check("reset rd_width", int'(rd_width), 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset busy", busy, 0);
        check("reset sat_err", sat_err, 0);
        check("reset upd_ready", upd_ready, 1);
        check("reset state", state_dbg, 0);
        rst = 1'b0;
        model_reset();

        // ---- read after reset: 13, 0, 5 ----
        read3(13, 0, 5);
        check("rst read valid", rd_valid, 1);
        check("rst read p0", port_w(0), 127);
        check("rst read p1", port_w(1), 0);
        check("rst read p2", port_w(2), 0);
        step();
        check("rd_valid pulse", rd_valid, 0);
        check("rd_width hold", port_w(0), 127);

        // ---- table-driven updates ----
        for (int i = 0; i < 17; i++) begin
            do_update(vecs[i].op, vecs[i].id, vecs[i].amt);
            check($sformatf("vec%0d sat_err", i), sat_err, vecs[i].exp_sat);
            pid = $urandom_range(0, NUM_ID - 1);
            read3(vecs[i].id, BLOCK_ID, pid);
            check($sformatf("vec%0d sat_err drop", i), sat_err, 0);
            check($sformatf("vec%0d rd_valid", i), rd_valid, 1);
            check($sformatf("vec%0d value", i), port_w(0), vecs[i].exp_val);
            check($sformatf("vec%0d pinned", i), port_w(1), WMAX);
            check($sformatf("vec%0d other", i), port_w(2), model[pid]);
        end

        // ---- clear sweep with simultaneous update ----
        do_update(1'b0, 3, 20);
        upd_valid = 1'b1; upd_op = 1'b0; upd_id = 4'd3; upd_amt = 5'd4;
        clr_req = 1'b1;
        step();
        upd_id = 4'd8; upd_amt = 5'd5;
        rd_en = 1'b1; rd_id = {4'd3, 4'd3, 4'd3};
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            busy_cnt++;
            check("clr upd_ready", upd_ready, 0);
            check("clr rd_valid", rd_valid, 0);
            step();
        end
        idle_inputs();
        check("clr busy cycles", busy_cnt, NUM_ID);
        check("clr last rd ignored", rd_valid, 0);
        check("clr upd_ready back", upd_ready, 1);
        model_reset();
        read3(3, 13, 8);
        check("clr id3", port_w(0), 0);
        check("clr id13", port_w(1), 127);
        check("clr id8", port_w(2), 0);

        // ---- same-cycle update and read of ID 6 ----
        do_update(1'b0, 6, 8);
        upd_valid = 1'b1; upd_op = 1'b0; upd_id = 4'd6; upd_amt = 5'd4;
        rd_en = 1'b1; rd_id = {4'd6, 4'd6, 4'd6};
        step();
        idle_inputs();
        model[6] = 12;
        for (int k = 0; k < NUM_RD; k++)
            check($sformatf("bypass p%0d", k), port_w(k), BYPASS ? 12 : 8);
        read3(6, 6, 6);
        check("bypass after", port_w(0), 12);

        // ---- randomized traffic against the model ----
        prev_re = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v   = ($urandom_range(0, 9) < 7);
            op  = ($urandom_range(0, 2) == 0);
            id  = $urandom_range(0, NUM_ID - 1);
            amt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
            re  = $urandom_range(0, 1);
            for (int k = 0; k < NUM_RD; k++) rids[k] = $urandom_range(0, NUM_ID - 1);
            upd_valid = v; upd_op = op; upd_id = ID_W'(id); upd_amt = UPD_W'(amt);
            rd_en = re;
            rd_id = {ID_W'(rids[2]), ID_W'(rids[1]), ID_W'(rids[0])};
            es = v && ref_writable(id) && ref_sat(model[id], op, amt);
            if (re) begin
                for (int k = 0; k < NUM_RD; k++) begin
                    exp_v = model[rids[k]];
                    if (BYPASS && v && ref_writable(id) && rids[k] == id)
                        exp_v = ref_next(model[id], op, amt);
                    exp_q.push_back(ACC_W'(exp_v));
                end
            end
            if (v && ref_writable(id)) model[id] = ref_next(model[id], op, amt);
            step();
            prev_re = re;
            check("rand sat_err", sat_err, es);
            check("rand rd_valid", rd_valid, prev_re);
            if (prev_re) begin
                for (int k = 0; k < NUM_RD; k++) begin
                    if (exp_q.size() == 0) begin
                        check("rand queue empty", 0, 1);
                    end else begin
                        exp_v = int'(exp_q.pop_front());
                        check($sformatf("rand p%0d", k), port_w(k), exp_v);
                    end
                end
            end
        end
        idle_inputs();

        // ---- reset in the middle of a sweep ----
        do_update(1'b0, 10, 30);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (5) step();
        check("midclr busy", busy, 1);
        rst = 1'b1;
        step();
        check("midclr rst busy", busy, 0);
        check("midclr rst ready", upd_ready, 1);
        rst = 1'b0;
        model_reset();
        step();
        check("midclr stays idle", busy, 0);
        read3(13, 10, 7);
        check("midclr id13", port_w(0), 127);
        check("midclr id10", port_w(1), 0);
        check("midclr id7", port_w(2), 0);

        // ---- 14-entry instance: IDs 13 (pinned) and 15 (absent) ----
        upd_valid_b = 1'b1; upd_op_b = 1'b0; upd_id_b = 4'd15; upd_amt_b = 5'd9;
        check("n14 ready id15", upd_ready_b, 1);
        step();
        check("n14 sat id15", sat_err_b, 0);
        upd_id_b = 4'd13;
        check("n14 ready id13", upd_ready_b, 1);
        step();
        upd_valid_b = 1'b0;
        check("n14 sat id13", sat_err_b, 0);
        rd_en_b = 1'b1; rd_id_b = {4'd14, 4'd13, 4'd15};
        step();
        rd_en_b = 1'b0;
        check("n14 rd_valid", rd_valid_b, 1);
        check("n14 id15", port_wb(0), 0);
        check("n14 id13", port_wb(1), 127);
        check("n14 id14", port_wb(2), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
